// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator and the
// detector benches it feeds.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero rather than
// wrapping.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first repeat_n times with an
// optional gap of zeros between repetitions, start/busy/done handshake.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  output logic             dout,
  output logic             dvalid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  state_t           state;
  state_t           state_next;
  logic [GAP_W-1:0] gap_len;
  logic [PAT_W-1:0] shift;
  logic             accept;
  logic             idx_load, idx_dec, idx_zero;
  logic             reps_load, reps_dec, reps_zero;
  logic             gap_load, gap_dec, gap_zero;

  assign accept = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gap_len <= '0;
      shift   <= '0;
    end else begin
      state <= state_next;
      if (accept) gap_len <= gap_n;
      // The shift register tracks the bit index counter: its MSB is PATTERN[idx].
      if (idx_load)     shift <= PATTERN;
      else if (idx_dec) shift <= shift << 1;
    end
  end

  always_comb begin
    state_next = state;
    idx_load   = 1'b0;
    idx_dec    = 1'b0;
    reps_load  = 1'b0;
    reps_dec   = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (repeat_n == '0) begin
              state_next = DONE;
            end else begin
              state_next = SEND;
              idx_load   = 1'b1;
              reps_load  = 1'b1;
            end
          end
        end
        SEND: begin
          if (idx_zero) begin
            idx_load = 1'b1;
            // reps counter holds repetitions remaining after the current one
            if (reps_zero) begin
              state_next = DONE;
            end else begin
              reps_dec = 1'b1;
              if (gap_len != '0) begin
                state_next = GAP;
                gap_load   = 1'b1;
              end
            end
          end else begin
            idx_dec = 1'b1;
          end
        end
        GAP: begin
          if (gap_zero) begin
            state_next = SEND;
            idx_load   = 1'b1;
          end else begin
            gap_dec = 1'b1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  seq_down_counter #(.W(IDX_W)) u_idx (
    .clk(clk), .reset(reset), .load(idx_load), .value(IDX_MAX),
    .dec(idx_dec), .zero(idx_zero)
  );

  seq_down_counter #(.W(CNT_W)) u_reps (
    .clk(clk), .reset(reset), .load(reps_load), .value(repeat_n - CNT_W'(1)),
    .dec(reps_dec), .zero(reps_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .reset(reset), .load(gap_load), .value(gap_len - GAP_W'(1)),
    .dec(gap_dec), .zero(gap_zero)
  );

  assign dout     = (state == SEND) && shift[PAT_W-1];
  assign dvalid   = (state == SEND);
  assign last_bit = (state == SEND) && idx_zero;
  assign busy     = (state == SEND) || (state == GAP);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: table of transactions with a
// per-cycle expected-output queue, plus abort and asynchronous reset cases.
module tb_seq_pattern_gen;

  typedef struct packed {
    logic dout;
    logic dvalid;
    logic last_bit;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    int rn;
    int gn;
    int restart_at;
    int abort_at;
    int exp_busy;
    int exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] repeat_n = '0;
  logic [3:0] gap_n = '0;
  logic       dout, dvalid, last_bit, busy, done;

  int   n_checks = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  vec_t vecs[10];

  seq_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .repeat_n(repeat_n), .gap_n(gap_n),
    .dout(dout), .dvalid(dvalid), .last_bit(last_bit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = {dout, dvalid, last_bit, busy, done};
    return o;
  endfunction

  task automatic check_obs(input string name, input int cyc, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d dout/dvalid/last_bit/busy/done got=%b required=%b",
               name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Reference model: expected outputs for cycles 1..N after the start edge.
  function automatic void build_expected(input int rn, input int gn, input int abort_at);
    logic [3:0] pat;
    obs_t       seq[$];
    pat = 4'b1010;
    for (int r = 0; r < rn; r++) begin
      for (int b = 3; b >= 0; b--) seq.push_back({pat[b], 1'b1, (b == 0), 1'b1, 1'b0});
      if (r < rn - 1)
        for (int g = 0; g < gn; g++) seq.push_back(5'b00010);
    end
    seq.push_back(5'b00001);
    for (int i = 0; i < 3; i++) seq.push_back(5'b00000);
    if (abort_at > 0)
      for (int i = abort_at; i < seq.size(); i++) seq[i] = 5'b00000;
    exp_q = seq;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    obs_t got, e;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   fail_before = n_fail;
    build_expected(v.rn, v.gn, v.abort_at);
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    repeat_n = 8'(v.rn); gap_n = 4'(v.gn);
    @(posedge clk); #1;
    start = 1'b0;
    repeat_n = 8'($urandom); gap_n = 4'($urandom);
    while (exp_q.size() > 0) begin
      cyc++;
      start = (cyc == v.restart_at);
      abort = (cyc == v.abort_at);
      @(negedge clk);
      got = sample();
      e = exp_q.pop_front();
      check_obs($sformatf("vec%0d", id), cyc, got, e);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
    check_int($sformatf("vec%0d_busy_cycles", id), busy_cnt, v.exp_busy);
    check_int($sformatf("vec%0d_done_pulses", id), done_cnt, v.exp_done);
    $display("txn %0d: repeat_n=%0d gap_n=%0d restart_at=%0d abort_at=%0d busy=%0d done=%0d errors=%0d",
             id, v.rn, v.gn, v.restart_at, v.abort_at, busy_cnt, done_cnt, n_fail - fail_before);
  endtask

  initial begin
    obs_t got;
    //          rn   gn  restart abort busy  done
    vecs[0] = '{1,   0,  0,      0,    4,    1};
    vecs[1] = '{3,   0,  0,      0,    12,   1};
    vecs[2] = '{2,   2,  0,      0,    10,   1};
    vecs[3] = '{0,   0,  0,      0,    0,    1};
    vecs[4] = '{2,   0,  0,      2,    2,    0};
    vecs[5] = '{1,   0,  2,      0,    4,    1};
    vecs[6] = '{2,   1,  10,     0,    9,    1};
    vecs[7] = '{4,   1,  0,      0,    19,   1};
    vecs[8] = '{2,   15, 0,      0,    23,   1};
    vecs[9] = '{255, 0,  0,      0,    1020, 1};

    #2;
    check_obs("reset_state", 0, sample(), 5'b00000);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // abort and start together in IDLE: start is dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; repeat_n = 8'd3; gap_n = 4'd0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_obs("abort_with_start", c, sample(), 5'b00000);
    end
    $display("txn abort_with_start: errors so far=%0d", n_fail);

    // asynchronous reset in the middle of SEND
    @(negedge clk);
    start = 1'b1; repeat_n = 8'd1; gap_n = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check_obs("pre_reset_cycle3", 3, sample(), 5'b11010);
    reset = 1'b0;
    #1;
    check_obs("async_reset_immediate", 3, sample(), 5'b00000);
    @(negedge clk);
    check_obs("async_reset_hold", 4, sample(), 5'b00000);
    @(negedge clk);
    check_obs("async_reset_no_done", 5, sample(), 5'b00000);
    reset = 1'b1;
    $display("txn async_reset: errors so far=%0d", n_fail);
    run_vec(10, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial pattern transmitter: the stimulus-side counterpart to the team's Moore non-overlapping sequence detectors (e.g. 1010).
- Emits a fixed PAT_W-bit pattern MSB-first, one bit per clock, repeated a programmable number of times.
- Optional idle gap of zeros between repetitions.
- start/busy/done handshake.
- Drives the detector's serial input in self-checking benches and on-chip BIST.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
PATTERN, 4'b1010, pattern transmitted, MSB first
CNT_W, 8, width of repeat count
GAP_W, 4, width of inter-pattern gap count

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
start  in  1  request transmission; sampled only in IDLE
abort  in  1  synchronous cancel, any state
repeat_n  in  CNT_W  number of pattern repetitions, latched on accepted start
gap_n  in  GAP_W  idle cycles between repetitions, latched on accepted start
dout  out  1  serial data bit (registered)
dvalid  out  1  dout carries a pattern bit
last_bit  out  1  dout is bit 0 of the current repetition
busy  out  1  high in SEND and GAP
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0): asynchronous, immediate.
  - State IDLE.
  - dout, dvalid, last_bit, busy, done all 0.
  - Counters cleared.
- All outputs are registered Moore outputs (function of state/counters only).
- "Cycle n" means the n-th clock cycle after the edge that samples start.

States:
- IDLE: outputs 0.
  - If start=1 and abort=0, latch repeat_n and gap_n.
  - repeat_n=0 -> go to DONE.
  - Otherwise -> go to SEND, with bit index = PAT_W-1 and reps_left = repeat_n.
- SEND: dout = PATTERN[idx], dvalid=1, busy=1, last_bit=(idx==0).
  - idx decrements each cycle.
  - At idx==0, reps_left decrements and idx reloads PAT_W-1.
  - If reps_left was 1 -> DONE.
  - Else if gap==0 -> stay in SEND (back-to-back patterns, no bubble).
  - Else -> GAP.
- GAP: dout=0, dvalid=0, busy=1 for exactly gap_n cycles, then -> SEND.
- DONE: done=1, busy=0, for exactly one cycle, then -> IDLE.

Latency and counts:
- First bit appears in cycle 1.
- Total busy cycles = repeat_n*PAT_W + (repeat_n-1)*gap_n.
- done is asserted in the cycle after the final bit.

Handshake and boundary rules:
- start is ignored while busy=1 or in DONE; no queuing.
- repeat_n and gap_n changes after acceptance have no effect.
- abort=1 in any state: IDLE at the next edge, all outputs 0, no done pulse.
- abort and start together in IDLE: abort wins and start is dropped.
- repeat_n at its maximum (2^CNT_W-1) must run to completion without the counter wrapping.
- Asynchronous reset mid-SEND/GAP: outputs 0 immediately; no done pulse.

Decomposition:
- Package seq_gen_pkg holds:
  - State enum {IDLE, SEND, GAP, DONE} (2-bit encoding).
  - Default PATTERN constant 4'b1010, shared with the detector benches.
- One sub-module: seq_down_counter.
  - Loadable down-counter, parameter W.
  - Ports: load, value, dec, zero flag.
  - Instantiated three times: bit index, repetitions, gap.

Test Plan:
1. repeat_n=1, gap_n=0, start pulse -> dout=1,0,1,0 with dvalid=1 in cycles 1-4; last_bit only in cycle 4; done=1 in cycle 5; busy=1 in cycles 1-4 only.
2. repeat_n=3, gap_n=0 -> dout 101010101010 in cycles 1-12, contiguous; last_bit in cycles 4, 8, 12; done in cycle 13; the 1010 non-overlapping detector pulses 3 times.
3. repeat_n=2, gap_n=2 -> bits 1010 in cycles 1-4; dvalid=0 and dout=0 in cycles 5-6; bits 1010 in cycles 7-10; done in cycle 11.
4. repeat_n=0 -> dvalid never asserted, busy never asserted, done=1 in cycle 1, IDLE in cycle 2.
5. repeat_n=2, gap_n=0; assert abort in cycle 2 -> all outputs 0 from cycle 3, no done. Also: a second start pulse issued while busy in a normal run is ignored (same done timing as scenario 1).
6. Drive reset=0 asynchronously mid-cycle during SEND (e.g. cycle 3) -> outputs 0 before the next clk edge. After release, a new start with repeat_n=1 reproduces scenario 1 exactly.
